// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS32 fetch stage
//
// Purpose: PC-stage state encoding and datapath widths shared by
//          pc_next_unit and pc_target_sel.
package mips_pkg;

  localparam int PC_W   = 32;
  localparam int JIDX_W = 26;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - redirect priority encoder and target address generator
//
// Purpose: picks the redirect target among JR, conditional branch and J.
//          Priority: jr > branch > jump (EX-stage sources beat the ID-stage one).
// Ports:
//   jr_i, jr_target_i            JR resolved in EX and its rs value
//   pc_src_i, br_base_i,
//   br_offset_i                  taken branch, PC+4 of branch, word offset
//   jump_i, jump_index_i         J/JAL decoded in ID and instr[25:0]
//   pc_i                         current fetch address (supplies jump region)
//   redirect_o                   any redirect source active
//   target_o                     selected target, bits [1:0] always 00
import mips_pkg::*;

module pc_target_sel (
  input  logic              jr_i,
  input  logic [PC_W-1:0]   jr_target_i,
  input  logic              pc_src_i,
  input  logic [PC_W-1:0]   br_base_i,
  input  logic [PC_W-1:0]   br_offset_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              redirect_o,
  output logic [PC_W-1:0]   target_o
);

  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;

  // Offset is in words; the shift drops the two top bits, giving modulo-2^32 wrap.
  assign br_target = br_base_i + (br_offset_i << 2);
  // J keeps the 256 MB region of the current pc.
  assign j_target  = (pc_i & 32'hF000_0000) | {4'b0000, jump_index_i, 2'b00};

  assign redirect_o = jr_i | pc_src_i | jump_i;

  always_comb begin
    target_o = j_target;
    if (jr_i) begin
      target_o = jr_target_i & ~32'h3;
    end else if (pc_src_i) begin
      target_o = br_target & ~32'h3;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter register and fetch-address handshake
//
// Purpose: holds the PC, steps it on accepted fetches, redirects it on
//          jr/branch/jump and emits a one-cycle flush on every redirect.
// Ports:
//   clk, rst                     clock, async active-high reset
//   pc_src, br_base, br_offset   taken branch from EX
//   jump, jump_index             J/JAL from ID
//   jr, jr_target                JR from EX
//   stall                        hazard-unit hold
//   imem_ready                   instruction memory accepts the address
//   pc, pc_plus4                 fetch address (registered) and pc+4
//   fetch_valid, flush           registered request valid and squash pulse
import mips_pkg::*;

module pc_next_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BOOT_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_src,
  input  logic [PC_W-1:0]   br_base,
  input  logic [PC_W-1:0]   br_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_target,
  input  logic              stall,
  input  logic              imem_ready,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              fetch_valid,
  output logic              flush
);

  // Count value seen on the edge that ends the boot wait.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  pc_state_t       state_q;
  logic [3:0]      boot_cnt_q;
  logic [PC_W-1:0] pc_q;
  logic            fetch_valid_q;
  logic            flush_q;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic            accept;

  pc_target_sel u_target_sel (
    .jr_i         (jr),
    .jr_target_i  (jr_target),
    .pc_src_i     (pc_src),
    .br_base_i    (br_base),
    .br_offset_i  (br_offset),
    .jump_i       (jump),
    .jump_index_i (jump_index),
    .pc_i         (pc_q),
    .redirect_o   (redirect),
    .target_o     (target)
  );

  assign accept   = fetch_valid_q & imem_ready;
  assign pc_plus4 = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      boot_cnt_q    <= 4'd0;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (state_q == BOOT) begin
        // Redirect and stall have no meaning before the first fetch.
        boot_cnt_q <= boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_q       <= FETCH;
          fetch_valid_q <= 1'b1;
        end
      end else if (redirect) begin
        // Redirect beats stall and any accept happening this cycle.
        pc_q          <= target;
        flush_q       <= 1'b1;
        fetch_valid_q <= 1'b0;
        state_q       <= REDIR;
      end else if (stall) begin
        fetch_valid_q <= 1'b0;
        state_q       <= HOLD;
      end else begin
        // FETCH, or leaving HOLD/REDIR: the request is live next cycle.
        if (state_q == FETCH && accept) begin
          pc_q <= pc_plus4;
        end
        fetch_valid_q <= 1'b1;
        state_q       <= FETCH;
      end
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] br_base;
  logic [31:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_PC(32'h0000_0000), .BOOT_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .br_base     (br_base),
    .br_offset   (br_offset),
    .jump        (jump),
    .jump_index  (jump_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] epc,
                      input logic efv, input logic efl);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, efv});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, efl});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_src = 0; jump = 0; jr = 0; stall = 0;
  endtask

  initial begin
    rst = 1; clr(); br_base = 0; br_offset = 0; jump_index = 0;
    jr_target = 0; imem_ready = 1;
    #2;
    chk3("reset", 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: boot wait, then sequential fetch
    step(); chk3("boot1", 32'h0, 1'b0, 1'b0);
    step(); chk3("boot2", 32'h0, 1'b0, 1'b0);
    step(); chk3("boot3", 32'h0, 1'b0, 1'b0);
    step(); chk3("boot4", 32'h0, 1'b1, 1'b0);
    chk("pc_plus4_0", pc_plus4, 32'h4);
    step(); chk3("seq4", 32'h4, 1'b1, 1'b0);
    step(); chk3("seq8", 32'h8, 1'b1, 1'b0);

    // 2: move to 0x40 with a jump, then a backward branch
    jump = 1; jump_index = 26'h10;
    step(); chk3("j40", 32'h40, 1'b0, 1'b1);
    clr();
    step(); chk3("j40_bub", 32'h40, 1'b1, 1'b0);
    pc_src = 1; br_base = 32'h24; br_offset = 32'hFFFF_FFFE;
    step(); chk3("br1c", 32'h1C, 1'b0, 1'b1);
    clr();
    step(); chk3("br1c_bub", 32'h1C, 1'b1, 1'b0);
    step(); chk3("br_seq", 32'h20, 1'b1, 1'b0);

    // 3: all three sources at once, jr wins
    jr = 1; jr_target = 32'h1003; pc_src = 1; jump = 1;
    step(); chk3("prio", 32'h1000, 1'b0, 1'b1);
    clr();
    step(); chk3("prio_bub", 32'h1000, 1'b1, 1'b0);

    // 4: stall for 3 cycles at 0x80, then stall+jump
    jump = 1; jump_index = 26'h20;
    step(); chk3("j80", 32'h80, 1'b0, 1'b1);
    clr(); stall = 1;
    step(); chk3("stall1", 32'h80, 1'b0, 1'b0);
    step(); chk3("stall2", 32'h80, 1'b0, 1'b0);
    step(); chk3("stall3", 32'h80, 1'b0, 1'b0);
    jump = 1; jump_index = 26'h10;
    step(); chk3("stall_j", 32'h40, 1'b0, 1'b1);
    clr();
    step(); chk3("stall_j_bub", 32'h40, 1'b1, 1'b0);

    // 5: memory not ready holds the address
    jump = 1; jump_index = 26'h40;
    step(); chk3("j100", 32'h100, 1'b0, 1'b1);
    clr();
    step(); chk3("j100_bub", 32'h100, 1'b1, 1'b0);
    imem_ready = 0;
    step(); chk3("nrdy1", 32'h100, 1'b1, 1'b0);
    step(); chk3("nrdy2", 32'h100, 1'b1, 1'b0);
    imem_ready = 1;
    step(); chk3("rdy", 32'h104, 1'b1, 1'b0);

    // 6: wrap at top of memory, then async reset during REDIR
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step(); chk3("jr_top", 32'hFFFF_FFFC, 1'b0, 1'b1);
    clr();
    step(); chk3("top_bub", 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    step(); chk3("wrap", 32'h0, 1'b1, 1'b0);
    jump = 1; jump_index = 26'h10;
    step(); chk3("redir_pre_rst", 32'h40, 1'b0, 1'b1);
    #2 rst = 1;
    #1 chk3("async_rst", 32'h0, 1'b0, 1'b0);
    clr();
    #3 rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
